regfile_write_queue: RTL and testbench
======================================

Name: regfile_write_queue

Overview:
- Writer-side front end for the 32x32 register file (two read ports, one write port: wreg/wdata/write).
- Buffers register write requests from execution units in a small FIFO.
- Drains the FIFO one entry per cycle onto the register-file write port.
- Provides read-after-write forwarding to the two read ports so readers see pending data.

Parameters:
DEPTH, 4, number of FIFO entries (power of two, 2..16)
AW, 5, register address width
DW, 32, register data width

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  producer has a write request
in_ready  output  1  queue can accept a request this cycle
in_reg  input  AW  destination register of request
in_data  input  DW  data of request
drain_stall  input  1  register-file write port unavailable, do not pop
write  output  1  write enable to register file (registered)
wreg  output  AW  write register number to register file (registered)
wdata  output  DW  write data to register file (registered)
rno1  input  AW  read port 1 register number (same as register file rno1)
rno2  input  AW  read port 2 register number
fwd_hit1  output  1  pending write exists for rno1
fwd_data1  output  DW  youngest pending data for rno1 (0 when no hit)
fwd_hit2  output  1  pending write exists for rno2
fwd_data2  output  DW  youngest pending data for rno2 (0 when no hit)
count  output  log2(DEPTH)+1  entries currently in FIFO (excludes output stage)

Behaviour:
- Reset (rst_n low at rising edge): head, tail and count cleared to 0; write=0, wreg=0, wdata=0; all pending entries discarded, including an entry that was mid-drain. fwd_hit1/2=0 while the queue is empty.
- Push: accepted at an edge when in_valid && in_ready. in_ready = (count < DEPTH). It is combinational from count only; a same-cycle pop does not raise it.
- Pop: at an edge when count > 0 && !drain_stall. The head entry is loaded into the output stage and write=1 for the following cycle. Otherwise write=0 next cycle, and wreg/wdata hold their previous values.
- Latency: a request pushed into an empty queue at edge k is popped at edge k+1. write is high between edges k+1 and k+2. Sustained throughput is 1 entry per cycle.
- Simultaneous push and pop: both take effect; count unchanged. With count=DEPTH, the push is refused (in_ready=0) and the pop proceeds.
- Pointers wrap modulo DEPTH; count never exceeds DEPTH and never underflows.
- drain_stall high: no pop, FIFO contents held, pushes still accepted while not full.
- Forwarding (combinational):
  - Candidates are all valid FIFO entries plus the output stage while write=1.
  - A hit occurs when a candidate register equals rnoN.
  - When several candidates match, the youngest wins: the FIFO entry nearest the tail, then older FIFO entries, then the output stage.
  - No hit gives fwd_hitN=0, fwd_dataN=0.
  - rno1 and rno2 are independent; both may hit the same entry.
- Register 0 is an ordinary register: no special-casing on write or forward.
- Data ordering: writes reach the register file in push order; a later write to the same register is never reordered ahead of an earlier one.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles -> write=0, wreg=0, wdata=0, count=0, in_ready=1, fwd_hit1=fwd_hit2=0.
- Single write: push reg=5, data=0xDEADBEEF at edge k -> count=1 after k. After k+1: write=1, wreg=5, wdata=0xDEADBEEF, count=0. After k+2: write=0.
- Fill under stall: drain_stall=1, push regs 1,2,3,4 (data 0x11..0x44) -> count=4, in_ready=0; 5th push refused. Release stall -> write pulses 4 consecutive cycles with regs 1,2,3,4 in order.
- Forward youngest: stall, push reg=7 data=0xA then reg=7 data=0xB, rno1=7, rno2=8 -> fwd_hit1=1, fwd_data1=0xB, fwd_hit2=0, fwd_data2=0.
- Full with simultaneous push and pop: count=4, drain_stall=0, in_valid=1 -> in_ready=0, push refused, pop proceeds, count=3. Next cycle, push and pop both occur, count stays 3.
- Reset mid-drain: 3 entries queued, write=1 on output, assert rst_n=0 for one edge -> write=0, count=0, no further write pulses after release.

Source files
------------

// File: rtl/regfile_write_queue.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_queue
// Purpose  : FIFO-buffered write front end for the register file, with
//            youngest-wins read-after-write forwarding on both read ports.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_write_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [AW-1:0]            in_reg,
    input  logic [DW-1:0]            in_data,
    input  logic                     drain_stall,
    output logic                     write,
    output logic [AW-1:0]            wreg,
    output logic [DW-1:0]            wdata,
    input  logic [AW-1:0]            rno1,
    input  logic [AW-1:0]            rno2,
    output logic                     fwd_hit1,
    output logic [DW-1:0]            fwd_data1,
    output logic                     fwd_hit2,
    output logic [DW-1:0]            fwd_data2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int               c_PW       = $clog2(DEPTH);
    localparam logic [c_PW-1:0]  c_PTR_ONE  = 1;
    localparam logic [c_PW:0]    c_CNT_ONE  = 1;
    localparam logic [c_PW:0]    c_CNT_FULL = (c_PW+1)'(DEPTH);

    logic [AW-1:0]   r_mem_reg  [DEPTH];
    logic [DW-1:0]   r_mem_data [DEPTH];
    logic [c_PW-1:0] r_head;
    logic [c_PW-1:0] r_tail;
    logic [c_PW:0]   r_count;
    logic            r_write;
    logic [AW-1:0]   r_wreg;
    logic [DW-1:0]   r_wdata;

    logic            w_push;
    logic            w_pop;
    logic [AW-1:0]   w_rno [2];

    // Full-ness alone gates acceptance; a same-cycle pop never frees a slot early.
    assign in_ready = (r_count < c_CNT_FULL);
    assign w_push   = in_valid && in_ready;
    assign w_pop    = (r_count != '0) && !drain_stall;

    assign count    = r_count;
    assign write    = r_write;
    assign wreg     = r_wreg;
    assign wdata    = r_wdata;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_reg[r_tail]  <= in_reg;
            r_mem_data[r_tail] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_write <= 1'b0;
            r_wreg  <= '0;
            r_wdata <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + c_PTR_ONE;
            end
            if (w_pop) begin
                r_head  <= r_head + c_PTR_ONE;
                r_wreg  <= r_mem_reg[r_head];
                r_wdata <= r_mem_data[r_head];
            end
            r_write <= w_pop;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_rno[0] = rno1;
    assign w_rno[1] = rno2;

    for (genvar p = 0; p < 2; p++) begin : g_fwd
        logic            w_hit;
        logic [DW-1:0]   w_data;
        logic [c_PW-1:0] w_idx;

        // Scan oldest to youngest so later matches overwrite earlier ones.
        always_comb begin
            w_hit  = r_write && (r_wreg == w_rno[p]);
            w_data = w_hit ? r_wdata : '0;
            w_idx  = '0;
            for (int i = 0; i < DEPTH; i++) begin
                w_idx = r_head + c_PW'(i);
                if (((c_PW+1)'(i) < r_count) && (r_mem_reg[w_idx] == w_rno[p])) begin
                    w_hit  = 1'b1;
                    w_data = r_mem_data[w_idx];
                end
            end
        end
    end

    assign fwd_hit1  = g_fwd[0].w_hit;
    assign fwd_data1 = g_fwd[0].w_data;
    assign fwd_hit2  = g_fwd[1].w_hit;
    assign fwd_data2 = g_fwd[1].w_data;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_write_queue
// Purpose  : Directed self-checking bench for regfile_write_queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_write_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_reg;
    logic [DW-1:0] in_data;
    logic          drain_stall;
    logic          write;
    logic [AW-1:0] wreg;
    logic [DW-1:0] wdata;
    logic [AW-1:0] rno1;
    logic [AW-1:0] rno2;
    logic          fwd_hit1;
    logic [DW-1:0] fwd_data1;
    logic          fwd_hit2;
    logic [DW-1:0] fwd_data2;
    logic [2:0]    count;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_write_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data),
        .drain_stall(drain_stall),
        .write(write), .wreg(wreg), .wdata(wdata),
        .rno1(rno1), .rno2(rno2),
        .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1),
        .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled there too.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic push_stalled(input logic [AW-1:0] r, input logic [DW-1:0] d);
        in_valid = 1'b1; in_reg = r; in_data = d;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_reg = '0; in_data = '0;
        drain_stall = 1'b0; rno1 = '0; rno2 = '0;

        // Reset then idle
        step(); step();
        #1;
        check("rst_write", write, 0);
        check("rst_wreg", wreg, 0);
        check("rst_wdata", wdata, 0);
        check("rst_count", count, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_hit1_r0", fwd_hit1, 0);
        check("rst_hit2_r0", fwd_hit2, 0);
        rst_n = 1'b1;
        step();

        // Single write
        in_valid = 1'b1; in_reg = 5'd5; in_data = 32'hDEADBEEF;
        step();
        in_valid = 1'b0; rno1 = 5'd5; #1;
        check("single_cnt_k", count, 1);
        check("single_write_k", write, 0);
        check("single_fwd_fifo_hit", fwd_hit1, 1);
        check("single_fwd_fifo_data", fwd_data1, 32'hDEADBEEF);
        step();
        check("single_write_k1", write, 1);
        check("single_wreg_k1", wreg, 5);
        check("single_wdata_k1", wdata, 32'hDEADBEEF);
        check("single_cnt_k1", count, 0);
        check("single_fwd_out_hit", fwd_hit1, 1);
        check("single_fwd_out_data", fwd_data1, 32'hDEADBEEF);
        step();
        check("single_write_k2", write, 0);
        check("single_wreg_hold", wreg, 5);
        check("single_fwd_gone", fwd_hit1, 0);
        check("single_fwd_gone_d", fwd_data1, 0);

        // Fill under stall
        drain_stall = 1'b1;
        for (int i = 1; i <= 4; i++) push_stalled(AW'(i), DW'(i * 32'h11));
        check("fill_cnt", count, 4);
        check("fill_in_ready", in_ready, 0);
        in_valid = 1'b1; in_reg = 5'd9; in_data = 32'h99;
        step();
        in_valid = 1'b0; rno1 = 5'd3; rno2 = 5'd9; #1;
        check("fill_refused_cnt", count, 4);
        check("fill_fwd_hit1", fwd_hit1, 1);
        check("fill_fwd_data1", fwd_data1, 32'h33);
        check("fill_fwd_hit2", fwd_hit2, 0);
        drain_stall = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            check("drain_write", write, 1);
            check("drain_wreg", wreg, AW'(i));
            check("drain_wdata", wdata, DW'(i * 32'h11));
            check("drain_cnt", count, 3'(4 - i));
        end
        step();
        check("drain_done", write, 0);

        // Forward youngest
        drain_stall = 1'b1;
        push_stalled(5'd7, 32'hA);
        push_stalled(5'd7, 32'hB);
        rno1 = 5'd7; rno2 = 5'd8; #1;
        check("young_hit1", fwd_hit1, 1);
        check("young_data1", fwd_data1, 32'hB);
        check("young_hit2", fwd_hit2, 0);
        check("young_data2", fwd_data2, 0);
        drain_stall = 1'b0;
        step();
        check("young_pop1_wdata", wdata, 32'hA);
        check("young_fifo_over_out", fwd_data1, 32'hB);
        step();
        check("young_pop2_wdata", wdata, 32'hB);
        check("young_out_only", fwd_data1, 32'hB);
        step();
        check("young_idle", write, 0);

        // Full with simultaneous push and pop
        drain_stall = 1'b1;
        for (int i = 0; i < 4; i++) push_stalled(AW'(10 + i), DW'(32'h100 + i));
        drain_stall = 1'b0; in_valid = 1'b1; in_reg = 5'd14; in_data = 32'h104; #1;
        check("full_in_ready", in_ready, 0);
        step();
        check("full_pop_cnt", count, 3);
        check("full_pop_wreg", wreg, 10);
        check("full_in_ready_after", in_ready, 1);
        step();
        in_valid = 1'b0;
        check("pushpop_cnt", count, 3);
        check("pushpop_wreg", wreg, 11);
        for (int i = 0; i < 3; i++) begin
            step();
            check("pp_drain_wreg", wreg, AW'(12 + i));
            check("pp_drain_wdata", wdata, DW'(32'h102 + i));
            check("pp_drain_cnt", count, 3'(2 - i));
        end
        step();
        check("pp_idle", write, 0);

        // Reset mid-drain
        drain_stall = 1'b1;
        for (int i = 0; i < 3; i++) push_stalled(AW'(20 + i), DW'(32'h200 + i));
        drain_stall = 1'b0;
        step();
        check("mid_write", write, 1);
        check("mid_cnt", count, 2);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mid_rst_write", write, 0);
        check("mid_rst_cnt", count, 0);
        check("mid_rst_wreg", wreg, 0);
        check("mid_rst_wdata", wdata, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("mid_no_write", write, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
